// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IF,
    ARB_LS
  } arb_state_e;

  localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
interface mem_arbiter_if #(
  parameter int ADDRESS = 32,
  parameter int DATA    = 32
);

  logic               if_req;
  logic [ADDRESS-1:0] if_addr;
  logic               if_gnt;
  logic               if_valid;
  logic [DATA-1:0]    if_rdata;

  logic               ls_req;
  logic               ls_we_re;
  logic [3:0]         ls_mask;
  logic [ADDRESS-1:0] ls_addr;
  logic [DATA-1:0]    ls_wdata;
  logic               ls_gnt;
  logic               ls_valid;
  logic [DATA-1:0]    ls_rdata;

  logic               mem_request;
  logic               mem_we_re;
  logic [3:0]         mem_mask;
  logic [ADDRESS-1:0] mem_addr;
  logic [DATA-1:0]    mem_wdata;
  logic               mem_ack;
  logic [DATA-1:0]    mem_rdata;

  logic               stall_fetch;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we_re, ls_mask, ls_addr, ls_wdata,
    input  mem_ack, mem_rdata,
    output if_gnt, if_valid, if_rdata,
    output ls_gnt, ls_valid, ls_rdata,
    output mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
    output stall_fetch
  );

  // Requester / memory-model view.
  modport master (
    output if_req, if_addr,
    output ls_req, ls_we_re, ls_mask, ls_addr, ls_wdata,
    output mem_ack, mem_rdata,
    input  if_gnt, if_valid, if_rdata,
    input  ls_gnt, ls_valid, ls_rdata,
    input  mem_request, mem_we_re, mem_mask, mem_addr, mem_wdata,
    input  stall_fetch
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and the LSU: data-side priority,
// starvation guard for fetch, one outstanding transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS      = 32,
  parameter int DATA         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_cnt;
  logic          gnt_if, gnt_ls;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_if  = 1'b0;
    gnt_ls  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (bus.if_req && (!bus.ls_req || starve_cnt == STARVE_MAX)) begin
          gnt_if  = 1'b1;
          state_d = ARB_IF;
        end else if (bus.ls_req) begin
          gnt_ls  = 1'b1;
          state_d = ARB_LS;
        end
      end
      ARB_IF, ARB_LS: begin
        if (bus.mem_ack) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.if_gnt      = gnt_if;
  assign bus.ls_gnt      = gnt_ls;
  assign bus.stall_fetch = bus.if_req & ~gnt_if;

  // Transaction fields are captured at grant so requesters are free to move on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_request <= 1'b0;
      bus.mem_we_re   <= 1'b0;
      bus.mem_mask    <= 4'b0000;
      bus.mem_addr    <= {ADDRESS{1'b0}};
      bus.mem_wdata   <= {DATA{1'b0}};
      bus.if_valid    <= 1'b0;
      bus.ls_valid    <= 1'b0;
      bus.if_rdata    <= {DATA{1'b0}};
      bus.ls_rdata    <= {DATA{1'b0}};
    end else begin
      bus.if_valid <= 1'b0;
      bus.ls_valid <= 1'b0;
      if (gnt_if) begin
        bus.mem_request <= 1'b1;
        bus.mem_we_re   <= 1'b0;
        bus.mem_mask    <= MASK_WORD;
        bus.mem_addr    <= bus.if_addr;
        bus.mem_wdata   <= {DATA{1'b0}};
      end else if (gnt_ls) begin
        bus.mem_request <= 1'b1;
        bus.mem_we_re   <= bus.ls_we_re;
        bus.mem_mask    <= bus.ls_mask;
        bus.mem_addr    <= bus.ls_addr;
        bus.mem_wdata   <= bus.ls_wdata;
      end else if (bus.mem_ack && state_q != ARB_IDLE) begin
        bus.mem_request <= 1'b0;
        if (state_q == ARB_IF) begin
          bus.if_valid <= 1'b1;
          bus.if_rdata <= bus.mem_rdata;
        end else begin
          bus.ls_valid <= 1'b1;
          if (!bus.mem_we_re) bus.ls_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  // Counts LS wins that happened while fetch was waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (gnt_if) begin
      starve_cnt <= '0;
    end else if (gnt_ls && bus.if_req && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDRESS(32), .DATA(32)) bus ();

  mem_arbiter #(.ADDRESS(32), .DATA(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the port, what was issued, fairness counter.
  int          m_owner;   // 0 none, 1 fetch, 2 lsu
  txn_t        m_txn;
  int          m_starve;
  logic        m_req, m_if_valid, m_ls_valid;
  logic [31:0] m_if_rdata, m_ls_rdata;

  logic obs_if_gnt, obs_ls_gnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = 0;
    m_txn      = '{addr: 32'h0, we: 1'b0, mask: 4'h0, wdata: 32'h0};
    m_starve   = 0;
    m_req      = 1'b0;
    m_if_valid = 1'b0;
    m_ls_valid = 1'b0;
    m_if_rdata = 32'h0;
    m_ls_rdata = 32'h0;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.ls_req    = 1'b0;
    bus.ls_we_re  = 1'b0;
    bus.ls_mask   = 4'h0;
    bus.ls_addr   = 32'h0;
    bus.ls_wdata  = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  // One clock: called at a negedge with inputs already driven.
  task automatic cycle();
    logic gi, gl;
    #1;
    gi = (m_owner == 0) && bus.if_req && (!bus.ls_req || m_starve == LIMIT);
    gl = (m_owner == 0) && !gi && bus.ls_req;
    obs_if_gnt = bus.if_gnt;
    obs_ls_gnt = bus.ls_gnt;
    check("if_gnt", bus.if_gnt, gi);
    check("ls_gnt", bus.ls_gnt, gl);
    check("stall_fetch", bus.stall_fetch, bus.if_req & ~gi);
    @(posedge clk);
    m_if_valid = 1'b0;
    m_ls_valid = 1'b0;
    if (m_owner == 0) begin
      if (gi) begin
        m_owner  = 1;
        m_txn    = '{addr: bus.if_addr, we: 1'b0, mask: 4'hF, wdata: 32'h0};
        m_starve = 0;
      end else if (gl) begin
        m_owner = 2;
        m_txn   = '{addr: bus.ls_addr, we: bus.ls_we_re, mask: bus.ls_mask, wdata: bus.ls_wdata};
        if (bus.if_req && m_starve < LIMIT) m_starve++;
      end
    end else if (bus.mem_ack) begin
      if (m_owner == 1) begin
        m_if_valid = 1'b1;
        m_if_rdata = bus.mem_rdata;
      end else begin
        m_ls_valid = 1'b1;
        if (!m_txn.we) m_ls_rdata = bus.mem_rdata;
      end
      m_owner = 0;
    end
    m_req = (m_owner != 0);
    #1;
    check("mem_request", bus.mem_request, m_req);
    check("mem_addr", bus.mem_addr, m_txn.addr);
    check("mem_we_re", bus.mem_we_re, m_txn.we);
    check("mem_mask", bus.mem_mask, m_txn.mask);
    check("mem_wdata", bus.mem_wdata, m_txn.wdata);
    check("if_valid", bus.if_valid, m_if_valid);
    check("ls_valid", bus.ls_valid, m_ls_valid);
    check("if_rdata", bus.if_rdata, m_if_rdata);
    check("ls_rdata", bus.ls_rdata, m_ls_rdata);
    check("starve_cnt", dut.starve_cnt, m_starve);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; called at a negedge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_mem_request", bus.mem_request, 1'b0);
    check("rst_mem_we_re", bus.mem_we_re, 1'b0);
    check("rst_mem_mask", bus.mem_mask, 4'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_ls_valid", bus.ls_valid, 1'b0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_ls_rdata", bus.ls_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic seq_exp [6];
  int   seq_n;

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Fetch only: grant cycle 0, ack cycle 2, valid cycle 3.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    cycle();
    check("fetch_gnt", obs_if_gnt, 1'b1);
    idle_inputs();
    cycle();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    cycle();
    idle_inputs();
    check("fetch_valid", bus.if_valid, 1'b1);
    check("fetch_rdata", bus.if_rdata, 32'h0050_0093);
    cycle();

    // Simultaneous requests: LSU first, fetch granted in the ls_valid cycle.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0014;
    bus.ls_req  = 1'b1;
    bus.ls_addr = 32'h0000_0100;
    bus.ls_mask = 4'hF;
    cycle();
    check("simul_ls_first", obs_ls_gnt, 1'b1);
    bus.ls_req = 1'b0;
    cycle();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    cycle();
    bus.mem_ack = 1'b0;
    check("simul_ls_valid", bus.ls_valid, 1'b1);
    cycle();
    check("simul_if_after", obs_if_gnt, 1'b1);
    bus.if_req    = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    cycle();
    idle_inputs();
    cycle();

    // Store leaves ls_rdata untouched.
    bus.ls_req   = 1'b1;
    bus.ls_we_re = 1'b1;
    bus.ls_mask  = 4'b0011;
    bus.ls_addr  = 32'h0000_0204;
    bus.ls_wdata = 32'hDEAD_BEEF;
    cycle();
    idle_inputs();
    check("store_addr", bus.mem_addr, 32'h0000_0204);
    check("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("store_mask", bus.mem_mask, 4'b0011);
    check("store_we", bus.mem_we_re, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    cycle();
    idle_inputs();
    check("store_valid", bus.ls_valid, 1'b1);
    check("store_rdata_kept", bus.ls_rdata, 32'hCAFE_0001);
    cycle();

    // Starvation guard from a clean counter: L L L L I L.
    do_reset();
    seq_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    seq_n = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    bus.ls_req  = 1'b1;
    bus.ls_addr = 32'h0000_0300;
    bus.ls_mask = 4'hF;
    for (int k = 0; k < 40 && seq_n < 6; k++) begin
      bus.mem_ack   = (m_owner != 0);
      bus.mem_rdata = 32'h100 + k;
      cycle();
      if (obs_if_gnt || obs_ls_gnt) begin
        check("starve_seq", obs_if_gnt, seq_exp[seq_n]);
        seq_n++;
      end
    end
    check("starve_seq_len", seq_n, 6);
    idle_inputs();
    bus.mem_ack = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // Reset during a fetch transaction; the late ack must be ignored.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0080;
    cycle();
    idle_inputs();
    do_reset();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_0BAD;
    cycle();
    check("late_ack_no_valid", bus.if_valid, 1'b0);
    check("late_ack_no_req", bus.mem_request, 1'b0);

    // Stray ack in idle: nothing happens.
    cycle();
    check("idle_ack_state", dut.state_q, 2'd0);
    idle_inputs();
    cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      bus.if_req    = ($urandom_range(0, 9) < 6);
      bus.if_addr   = $urandom;
      bus.ls_req    = ($urandom_range(0, 9) < 6);
      bus.ls_we_re  = $urandom_range(0, 1);
      bus.ls_mask   = $urandom_range(0, 15);
      bus.ls_addr   = $urandom;
      bus.ls_wdata  = $urandom;
      bus.mem_ack   = (m_owner != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
      bus.mem_rdata = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port of the rv32i core between the fetch stage (instruction reads) and the load/store unit (data reads and writes). Arbitrates in an IDLE state with data-side priority and a starvation guard for fetch. Holds one outstanding transaction at a time and returns read data with a one-cycle valid pulse. Sits between Fetch_stage/LSU and the memory model; its mem_* outputs replace the constant request/we_re/mask currently driven by the fetch stage.

## Interface
- ADDRESS, 32, address width
- DATA, 32, data width
- STARVE_LIMIT, 4, consecutive LS grants allowed while fetch waits (must be ≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch requests a read
- if_addr  in  ADDRESS  fetch address (PC)
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_valid  out  1  one-cycle pulse: if_rdata holds the instruction
- if_rdata  out  DATA  latched instruction
- ls_req  in  1  LSU requests an access
- ls_we_re  in  1  1 = write, 0 = read
- ls_mask  in  4  byte enables
- ls_addr  in  ADDRESS  data address
- ls_wdata  in  DATA  store data
- ls_gnt  out  1  LSU request accepted this cycle (combinational)
- ls_valid  out  1  one-cycle pulse: access complete (read or write)
- ls_rdata  out  DATA  latched load data
- mem_request  out  1  transaction outstanding
- mem_we_re  out  1  write strobe to memory
- mem_mask  out  4  byte enables to memory
- mem_addr  out  ADDRESS  memory address
- mem_wdata  out  DATA  memory write data
- mem_ack  in  1  memory completes current transaction; mem_rdata valid
- mem_rdata  in  DATA  memory read data
- stall_fetch  out  1  if_req & ~if_gnt

## Operation
- States: ARB_IDLE, ARB_IF, ARB_LS.
- ARB_IDLE: winner = IF if if_req & (~ls_req | starve_cnt == STARVE_LIMIT); else LS if ls_req; else none. Winner's gnt high combinationally; at clock edge state ← ARB_IF/ARB_LS, mem_* registered, mem_request ← 1.
- IF transaction: mem_addr = if_addr, mem_we_re = 0, mem_mask = 4'b1111, mem_wdata = 0.
- LS transaction: mem_* = ls_addr/ls_we_re/ls_mask/ls_wdata.
- ARB_IF/ARB_LS: mem_* held stable, no grants, requests ignored. On mem_ack: mem_request ← 0, state ← ARB_IDLE, owner's valid ← 1 for one cycle; rdata latched into owner's rdata only on reads (ls write leaves ls_rdata unchanged).
- mem_ack in ARB_IDLE is ignored.
- starve_cnt (width $clog2(STARVE_LIMIT+1)): +1 on LS grant while if_req high, saturates at STARVE_LIMIT; cleared on IF grant; held otherwise.
- Requesters may change req/address after their gnt cycle; arbiter uses registered copies.

## Timing
- Reset (async, immediate): state ARB_IDLE; mem_request, mem_we_re 0; mem_mask, mem_addr, mem_wdata 0; if_valid, ls_valid 0; if_rdata, ls_rdata 0; starve_cnt 0.
- Grant in cycle N → mem_request high from N+1. Ack in cycle M ≥ N+1 → valid pulse and state ARB_IDLE in M+1 → next grant possible in M+1.
- Minimum request-to-valid latency: 2 cycles (gnt N, ack N+1, valid N+2).
- Reset mid-transaction: transaction abandoned, no valid pulse; a late ack after release lands in ARB_IDLE and is ignored.
- Simultaneous if_req & ls_req with starve_cnt < STARVE_LIMIT: LS wins.

## Structure
- Shared package mem_arb_pkg: typedef enum arb_state_e {ARB_IDLE, ARB_IF, ARB_LS}; constant MASK_WORD = 4'b1111.
- No sub-module; FSM, counter and registers in one flat module.

## Test plan
- Fetch only: if_req, if_addr 0x0000_0010 at cycle 0, mem_ack at cycle 2 with 0x0050_0093 → if_gnt cycle 0, mem_request cycles 1–2, mem_mask 4'b1111, if_valid cycle 3, if_rdata 0x0050_0093.
- Simultaneous if_req (0x14) and ls_req read (0x100) → ls_gnt first; if_gnt in the ls_valid cycle; stall_fetch high until then.
- Store: ls_we_re 1, ls_mask 4'b0011, ls_addr 0x204, ls_wdata 0xDEAD_BEEF → mem fields match exactly; ls_valid pulses after ack; ls_rdata unchanged.
- Starvation (STARVE_LIMIT 4): ls_req and if_req held high → 4 LS grants, then one IF grant, starve_cnt 0, then LS resumes.
- Reset during ARB_IF: rst asserted → mem_request 0 immediately; ack after release ignored; no if_valid.
- mem_ack pulsed in ARB_IDLE with no requests → no valid pulse, no state change.
